// File: rtl/ex11_pkg.sv
// Shared width default and select encodings for the ex11 selection network.
package ex11_pkg;

    localparam int WIDTH_DEFAULT = 4;

    // Output-stage (sel4) encodings
    localparam logic [1:0] OUT_MUX = 2'b00;
    localparam logic [1:0] OUT_D   = 2'b01;
    localparam logic [1:0] OUT_Z   = 2'b10;
    localparam logic [1:0] OUT_XOR = 2'b11;

    // Stage-B (sel2) encodings
    localparam logic [1:0] B1 = 2'd0;
    localparam logic [1:0] B2 = 2'd1;
    localparam logic [1:0] B3 = 2'd2;
    localparam logic [1:0] B4 = 2'd3;

endpackage

// File: rtl/ex11_mux4.sv
// WIDTH-parameterised 4:1 multiplexer; in<n>_i is chosen when sel_i == n.
module ex11_mux4 #(
    parameter int WIDTH = 4
) (
    input  logic [1:0]       sel_i,
    input  logic [WIDTH-1:0] in0_i,
    input  logic [WIDTH-1:0] in1_i,
    input  logic [WIDTH-1:0] in2_i,
    input  logic [WIDTH-1:0] in3_i,
    output logic [WIDTH-1:0] out_o
);

    always_comb begin
        // NOTE: default assignment first so every path drives out_o and no latch is inferred.
        out_o = in0_i;
        case (sel_i)
            2'd0:    out_o = in0_i;
            2'd1:    out_o = in1_i;
            2'd2:    out_o = in2_i;
            default: out_o = in3_i;
        endcase
    end

endmodule

// File: rtl/ex11_mux_pipe.sv
// Multi-level 4-bit selection network (2:1, 4:1, 2:1, 4:1) with a registered output g.
module ex11_mux_pipe
    import ex11_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] a2,
    input  logic [WIDTH-1:0] b1,
    input  logic [WIDTH-1:0] b2,
    input  logic [WIDTH-1:0] b3,
    input  logic [WIDTH-1:0] b4,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] z,
    input  logic             sel1,
    input  logic [1:0]       sel2,
    input  logic             sel3,
    input  logic [1:0]       sel4,
    output logic [WIDTH-1:0] g
);

    logic [WIDTH-1:0] m_a;
    logic [WIDTH-1:0] m_b;
    logic [WIDTH-1:0] m_c;
    logic [WIDTH-1:0] nxt_d;
    logic [WIDTH-1:0] g_q;
    logic [WIDTH-1:0] b_opts   [4];
    logic [WIDTH-1:0] out_opts [4];

    assign m_a = sel1 ? a2 : a1;

    assign b_opts[B1] = b1;
    assign b_opts[B2] = b2;
    assign b_opts[B3] = b3;
    assign b_opts[B4] = b4;

    ex11_mux4 #(.WIDTH(WIDTH)) u_stage_b (
        .sel_i (sel2),
        .in0_i (b_opts[0]),
        .in1_i (b_opts[1]),
        .in2_i (b_opts[2]),
        .in3_i (b_opts[3]),
        .out_o (m_b)
    );

    assign m_c = sel3 ? m_b : m_a;

    // The XOR term is formed ahead of the output mux so the mux stays a plain 4:1.
    assign out_opts[OUT_MUX] = m_c;
    assign out_opts[OUT_D]   = d;
    assign out_opts[OUT_Z]   = z;
    assign out_opts[OUT_XOR] = m_c ^ z;

    ex11_mux4 #(.WIDTH(WIDTH)) u_stage_out (
        .sel_i (sel4),
        .in0_i (out_opts[0]),
        .in1_i (out_opts[1]),
        .in2_i (out_opts[2]),
        .in3_i (out_opts[3]),
        .out_o (nxt_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_q <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            g_q <= nxt_d;
        end
    end

    assign g = g_q;

endmodule

// File: tb/tb_ex11_mux_pipe.sv
// Self-checking bench for ex11_mux_pipe: directed cases plus randomized traffic vs a table model.
module tb_ex11_mux_pipe;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] a1, a2, b1, b2, b3, b4, d, z;
    logic         sel1, sel3;
    logic [1:0]   sel2, sel4;
    logic [W-1:0] g;

    int n_checks = 0;
    int n_errors = 0;

    ex11_mux_pipe #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a1    (a1),
        .a2    (a2),
        .b1    (b1),
        .b2    (b2),
        .b3    (b3),
        .b4    (b4),
        .d     (d),
        .z     (z),
        .sel1  (sel1),
        .sel2  (sel2),
        .sel3  (sel3),
        .sel4  (sel4),
        .g     (g)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: each level is a table lookup indexed by its select.
    function automatic logic [W-1:0] model();
        logic [W-1:0] a_tab [2];
        logic [W-1:0] b_tab [4];
        logic [W-1:0] c;
        logic [W-1:0] o_tab [4];
        a_tab = '{a1, a2};
        b_tab = '{b1, b2, b3, b4};
        c = sel3 ? b_tab[sel2] : a_tab[sel1];
        o_tab = '{c, d, z, c ^ z};
        return o_tab[sel4];
    endfunction

    task automatic randomize_inputs();
        a1 = W'($urandom); a2 = W'($urandom);
        b1 = W'($urandom); b2 = W'($urandom);
        b3 = W'($urandom); b4 = W'($urandom);
        d  = W'($urandom); z  = W'($urandom);
        sel1 = 1'($urandom); sel2 = 2'($urandom);
        sel3 = 1'($urandom); sel4 = 2'($urandom);
    endtask

    // Called right after a falling edge with inputs already set.
    task automatic step_check(input string tag);
        logic [W-1:0] exp;
        exp = model();
        @(posedge clk);
        #1;
        check(tag, g, exp);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        randomize_inputs();
        // Reset held with random inputs: g stays zero across edges.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_hold", g, 4'b0000);
            randomize_inputs();
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Stage A path
        a1 = 4'b0011; a2 = 4'b1100; sel3 = 1'b0; sel4 = 2'b00;
        sel1 = 1'b0; step_check("stage_a_sel0");
        check("stage_a_sel0_const", g, 4'b0011);
        sel1 = 1'b1; step_check("stage_a_sel1");
        check("stage_a_sel1_const", g, 4'b1100);

        // Stage B sweep
        b1 = 4'b0001; b2 = 4'b0010; b3 = 4'b0100; b4 = 4'b1000;
        sel3 = 1'b1; sel4 = 2'b00;
        for (int s = 0; s < 4; s++) begin
            logic [W-1:0] onehot;
            onehot = W'(1) << s;
            sel2 = 2'(s);
            step_check("stage_b_sweep");
            check("stage_b_onehot", g, onehot);
        end

        // Direct inputs
        d = 4'b0110; z = 4'b0001;
        sel4 = 2'b01; step_check("direct_d");
        check("direct_d_const", g, 4'b0110);
        sel4 = 2'b10; step_check("direct_z");
        check("direct_z_const", g, 4'b0001);

        // XOR mode
        a1 = 4'b0010; sel1 = 1'b0; sel3 = 1'b0; z = 4'b0101; sel4 = 2'b11;
        step_check("xor_0111");
        check("xor_0111_const", g, 4'b0111);
        z = 4'b0010;
        step_check("xor_0000");
        check("xor_0000_const", g, 4'b0000);

        // Back-to-back sel4 sweep: one-cycle latency, no skipped or repeated values
        a1 = 4'b1001; sel1 = 1'b0; sel3 = 1'b0; d = 4'b0110; z = 4'b0011;
        begin
            logic [W-1:0] seq_exp [4];
            seq_exp = '{4'b1001, 4'b0110, 4'b0011, 4'b1010};
            for (int s = 0; s < 4; s++) begin
                sel4 = 2'(s);
                @(posedge clk);
                #1;
                check("b2b_seq", g, seq_exp[s]);
                @(negedge clk);
            end
        end

        // Async reset mid-cycle after g = 1010
        a1 = 4'b1010; sel1 = 1'b0; sel3 = 1'b0; sel4 = 2'b00;
        step_check("pre_async_reset");
        check("pre_async_reset_const", g, 4'b1010);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_immediate", g, 4'b0000);
        @(posedge clk);
        #1;
        check("async_reset_held", g, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        randomize_inputs();
        step_check("first_after_reset");

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            randomize_inputs();
            step_check("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
